// File: rtl/stego_addr_sequencer_pkg.sv
// Shared types and constants for the steganography address sequencer.
// Holds the pass states, the legal bits-per-pixel range and the bit cursor width.
package stego_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_PRIME,
      S_RUN,
      S_DONE
   } state_e;

   localparam int BPP_MIN   = 1;
   localparam int BPP_MAX   = 6;
   localparam int BIT_PTR_W = 5;

   function automatic logic bpp_ok(input logic [2:0] bpp);
      return (int'(bpp) >= BPP_MIN) && (int'(bpp) <= BPP_MAX);
   endfunction

endpackage

// File: rtl/stego_addr_sequencer_if.sv
// Control/status bundle between the encode-pass controller and the address sequencer.
// The master starts passes and feeds pixel flags; the sequencer (slave) returns the addresses.
interface stego_addr_sequencer_if #(
   parameter int IMG_AW  = 16,
   parameter int DATA_AW = 12
);
   logic               start;
   logic [2:0]         bpp;
   logic               edge_only;
   logic [DATA_AW-1:0] msg_words;
   logic               pix_valid;
   logic               flag_img_start;
   logic               flag_edge;
   logic [IMG_AW-1:0]  img_addr;
   logic [IMG_AW-1:0]  enc_addr;
   logic [DATA_AW-1:0] data_addr;
   logic [4:0]         bit_ptr;
   logic               embed_en;
   logic               busy;
   logic               msg_done;
   logic               done;
   logic               cfg_err;

   modport master (
      output start, bpp, edge_only, msg_words, pix_valid, flag_img_start, flag_edge,
      input  img_addr, enc_addr, data_addr, bit_ptr, embed_en, busy, msg_done, done, cfg_err
   );

   modport slave (
      input  start, bpp, edge_only, msg_words, pix_valid, flag_img_start, flag_edge,
      output img_addr, enc_addr, data_addr, bit_ptr, embed_en, busy, msg_done, done, cfg_err
   );
endinterface

// File: rtl/stego_addr_sequencer_bit_cursor.sv
// Message bit cursor: walks bpp-sized bit groups through each message word and
// raises msg_done when the word address reaches the latched message length.
module stego_bit_cursor
   import stego_pkg::*;
#(
   parameter int DATA_AW = 12,
   parameter int DATA_W  = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 clear_empty_i,
   input  logic                 embed_i,
   input  logic [2:0]           bpp_i,
   input  logic [DATA_AW-1:0]   msg_words_i,
   output logic [BIT_PTR_W-1:0] bit_ptr_o,
   output logic [DATA_AW-1:0]   data_addr_o,
   output logic                 msg_done_o
);
   localparam logic [5:0] WORD_BITS = 6'(DATA_W);

   logic [BIT_PTR_W-1:0] bit_ptr_q, bit_ptr_d;
   logic [DATA_AW-1:0]   data_addr_q, data_addr_d, data_inc;
   logic                 msg_done_q, msg_done_d;
   logic [5:0]           lookahead;

   // If the group after this one would not fit, the word tail is padding and we move on.
   assign lookahead = {1'b0, bit_ptr_q} + {2'b00, bpp_i, 1'b0};
   assign data_inc  = data_addr_q + DATA_AW'(1);

   always_comb begin
      bit_ptr_d   = bit_ptr_q;
      data_addr_d = data_addr_q;
      msg_done_d  = msg_done_q;
      if (clear_i) begin
         bit_ptr_d   = '0;
         data_addr_d = '0;
         msg_done_d  = clear_empty_i;
      end else if (embed_i) begin
         if (lookahead > WORD_BITS) begin
            bit_ptr_d   = '0;
            data_addr_d = data_inc;
            if (data_inc == msg_words_i) begin
               msg_done_d = 1'b1;
            end
         end else begin
            bit_ptr_d = bit_ptr_q + BIT_PTR_W'(bpp_i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_ptr_q   <= '0;
         data_addr_q <= '0;
         msg_done_q  <= 1'b0;
      end else begin
         bit_ptr_q   <= bit_ptr_d;
         data_addr_q <= data_addr_d;
         msg_done_q  <= msg_done_d;
      end
   end

   assign bit_ptr_o   = bit_ptr_q;
   assign data_addr_o = data_addr_q;
   assign msg_done_o  = msg_done_q;

endmodule

// File: rtl/stego_addr_sequencer.sv
// Encode-pass address sequencer: pass FSM, header/prime skipping, image and encoder
// address counters, latched pass configuration and the embed enable for the pixel encoder.
module stego_addr_sequencer
   import stego_pkg::*;
#(
   parameter int IMG_AW     = 16,
   parameter int IMG_PIXELS = 65536,
   parameter int DATA_AW    = 12,
   parameter int DATA_W     = 24,
   parameter int PRIME_CYC  = 1
) (
   input logic                   clk,
   input logic                   rst,
   stego_addr_sequencer_if.slave bus
);
   localparam logic [IMG_AW-1:0] IMG_LAST   = IMG_AW'(IMG_PIXELS - 1);
   localparam logic [15:0]       PRIME_LAST = (PRIME_CYC > 0) ? 16'(PRIME_CYC - 1) : 16'd0;

   state_e               state_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 cfg_err_q;
   logic [2:0]           bpp_q;
   logic                 edge_only_q;
   logic [DATA_AW-1:0]   msg_words_q;
   logic [IMG_AW-1:0]    img_addr_q;
   logic [IMG_AW-1:0]    enc_addr_q;
   logic [15:0]          prime_cnt_q;

   logic                 can_start, start_ok, start_bad, last_px, embed_en, msg_done;
   logic [BIT_PTR_W-1:0] bit_ptr;
   logic [DATA_AW-1:0]   data_addr;

   assign can_start = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign start_ok  = can_start && bpp_ok(bus.bpp);
   assign start_bad = can_start && !bpp_ok(bus.bpp);
   assign last_px   = (img_addr_q == IMG_LAST);
   assign embed_en  = (state_q == S_RUN) && bus.pix_valid && !msg_done &&
                      (!edge_only_q || bus.flag_edge);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         bpp_q       <= '0;
         edge_only_q <= 1'b0;
         msg_words_q <= '0;
         img_addr_q  <= '0;
         enc_addr_q  <= '0;
         prime_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q <= S_IDLE;
               if (start_ok) begin
                  state_q     <= S_WAIT;
                  busy_q      <= 1'b1;
                  cfg_err_q   <= 1'b0;
                  bpp_q       <= bus.bpp;
                  edge_only_q <= bus.edge_only;
                  msg_words_q <= bus.msg_words;
                  img_addr_q  <= '0;
                  enc_addr_q  <= '0;
                  prime_cnt_q <= '0;
               end else if (start_bad) begin
                  cfg_err_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.pix_valid) begin
                  if (!last_px) img_addr_q <= img_addr_q + IMG_AW'(1);
                  if (bus.flag_img_start) begin
                     prime_cnt_q <= '0;
                     if (PRIME_CYC == 0) state_q <= S_RUN;
                     else                state_q <= S_PRIME;
                  end
               end
            end
            S_PRIME: begin
               if (bus.pix_valid) begin
                  if (!last_px) img_addr_q <= img_addr_q + IMG_AW'(1);
                  if (prime_cnt_q == PRIME_LAST) state_q <= S_RUN;
                  else                           prime_cnt_q <= prime_cnt_q + 16'd1;
               end
            end
            S_RUN: begin
               // The final pixel ends the pass without wrapping the image address.
               if (bus.pix_valid) begin
                  enc_addr_q <= enc_addr_q + IMG_AW'(1);
                  if (last_px) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     img_addr_q <= img_addr_q + IMG_AW'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   stego_bit_cursor #(
      .DATA_AW (DATA_AW),
      .DATA_W  (DATA_W)
   ) u_cursor (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (start_ok),
      .clear_empty_i (bus.msg_words == '0),
      .embed_i       (embed_en),
      .bpp_i         (bpp_q),
      .msg_words_i   (msg_words_q),
      .bit_ptr_o     (bit_ptr),
      .data_addr_o   (data_addr),
      .msg_done_o    (msg_done)
   );

   assign bus.img_addr  = img_addr_q;
   assign bus.enc_addr  = enc_addr_q;
   assign bus.data_addr = data_addr;
   assign bus.bit_ptr   = bit_ptr;
   assign bus.embed_en  = embed_en;
   assign bus.busy      = busy_q;
   assign bus.msg_done  = msg_done;
   assign bus.done      = done_q;
   assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_stego_addr_sequencer.sv
// Bench for stego_addr_sequencer: per-cycle comparison against a count-based pass model,
// plus directed passes with hand-computed address and cursor expectations.
module tb_stego_addr_sequencer;
   localparam int IMG_AW     = 6;
   localparam int IMG_PIXELS = 40;
   localparam int DATA_AW    = 4;
   localparam int DATA_W     = 24;
   localparam int PRIME_CYC  = 1;

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_PRIME = 2;
   localparam int P_RUN   = 3;
   localparam int P_DONE  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stego_addr_sequencer_if #(.IMG_AW(IMG_AW), .DATA_AW(DATA_AW)) bus ();

   stego_addr_sequencer #(
      .IMG_AW     (IMG_AW),
      .IMG_PIXELS (IMG_PIXELS),
      .DATA_AW    (DATA_AW),
      .DATA_W     (DATA_W),
      .PRIME_CYC  (PRIME_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Pass model in terms of pixel and embed counts.
   int m_phase = P_IDLE;
   int m_pix = 0, m_enc = 0, m_k = 0, m_prime_left = 0;
   int m_bpp = 0, m_words = 0, m_edge = 0, m_cfg = 0;
   int m_busy = 0, m_donep = 0, m_err = 0;

   initial begin
      forever begin
         int per_word, e_da, e_bp, e_md, e_emb;
         @(negedge clk);
         per_word = 1; e_da = 0; e_bp = 0; e_md = 0;
         if (m_cfg != 0) begin
            per_word = DATA_W / m_bpp;
            e_da = (m_k / per_word) % (1 << DATA_AW);
            e_bp = (m_k % per_word) * m_bpp;
            e_md = (m_k >= m_words * per_word) ? 1 : 0;
         end
         e_emb = (m_phase == P_RUN && bus.pix_valid && e_md == 0 &&
                  (m_edge == 0 || bus.flag_edge)) ? 1 : 0;
         check("img_addr",  int'(bus.img_addr),  m_pix);
         check("enc_addr",  int'(bus.enc_addr),  m_enc);
         check("data_addr", int'(bus.data_addr), e_da);
         check("bit_ptr",   int'(bus.bit_ptr),   e_bp);
         check("msg_done",  int'(bus.msg_done),  e_md);
         check("embed_en",  int'(bus.embed_en),  e_emb);
         check("busy",      int'(bus.busy),      m_busy);
         check("done",      int'(bus.done),      m_donep);
         check("cfg_err",   int'(bus.cfg_err),   m_err);
         if (rst) begin
            m_phase = P_IDLE; m_pix = 0; m_enc = 0; m_k = 0; m_prime_left = 0;
            m_bpp = 0; m_words = 0; m_edge = 0; m_cfg = 0;
            m_busy = 0; m_donep = 0; m_err = 0;
         end else begin
            m_donep = 0;
            case (m_phase)
               P_IDLE, P_DONE: begin
                  m_phase = P_IDLE;
                  if (bus.start) begin
                     if (bus.bpp >= 1 && bus.bpp <= 6) begin
                        m_phase = P_WAIT; m_busy = 1; m_err = 0; m_cfg = 1;
                        m_bpp = int'(bus.bpp); m_edge = int'(bus.edge_only);
                        m_words = int'(bus.msg_words);
                        m_pix = 0; m_enc = 0; m_k = 0;
                     end else begin
                        m_err = 1;
                     end
                  end
               end
               P_WAIT: if (bus.pix_valid) begin
                  if (m_pix < IMG_PIXELS - 1) m_pix++;
                  if (bus.flag_img_start) begin
                     m_prime_left = PRIME_CYC;
                     m_phase = (PRIME_CYC == 0) ? P_RUN : P_PRIME;
                  end
               end
               P_PRIME: if (bus.pix_valid) begin
                  if (m_pix < IMG_PIXELS - 1) m_pix++;
                  m_prime_left--;
                  if (m_prime_left == 0) m_phase = P_RUN;
               end
               P_RUN: if (bus.pix_valid) begin
                  if (e_emb != 0) m_k++;
                  m_enc++;
                  if (m_pix == IMG_PIXELS - 1) begin
                     m_phase = P_DONE; m_busy = 0; m_donep = 1;
                  end else begin
                     m_pix++;
                  end
               end
               default: m_phase = P_IDLE;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic px(input logic pv, input logic fis, input logic fe);
      bus.pix_valid = pv; bus.flag_img_start = fis; bus.flag_edge = fe;
      tick();
   endtask

   task automatic do_start(input int bpp, input int eo, input int words);
      bus.start = 1'b1; bus.bpp = 3'(bpp); bus.edge_only = 1'(eo);
      bus.msg_words = DATA_AW'(words); bus.pix_valid = 1'b0;
      bus.flag_img_start = 1'b0; bus.flag_edge = 1'b0;
      tick();
      bus.start = 1'b0;
      $display("start: bpp=%0d edge_only=%0d msg_words=%0d -> busy=%0d cfg_err=%0d",
               bpp, eo, words, bus.busy, bus.cfg_err);
   endtask

   task automatic run_to_done(input int bound, output int dones);
      dones = 0;
      bus.pix_valid = 1'b1; bus.flag_img_start = 1'b0; bus.flag_edge = 1'b0;
      for (int n = 0; n < bound; n++) begin
         tick();
         if (bus.done) begin
            dones++;
            break;
         end
      end
      repeat (3) begin
         tick();
         if (bus.done) dones++;
      end
      $display("pass end: img_addr=%0d enc_addr=%0d data_addr=%0d done pulses=%0d",
               bus.img_addr, bus.enc_addr, bus.data_addr, dones);
   endtask

   initial begin
      int dones;
      int bseq [5];
      int dseq [5];
      bseq = '{0, 5, 10, 15, 0};
      dseq = '{0, 0, 0, 0, 1};
      bus.start = 1'b0; bus.bpp = '0; bus.edge_only = 1'b0; bus.msg_words = '0;
      bus.pix_valid = 1'b0; bus.flag_img_start = 1'b0; bus.flag_edge = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      $display("reset released");
      check("rst_busy", int'(bus.busy), 0);
      check("rst_img", int'(bus.img_addr), 0);
      check("rst_cfg_err", int'(bus.cfg_err), 0);

      // Illegal bpp is rejected.
      do_start(7, 0, 2);
      check("bad_bpp_cfg_err", int'(bus.cfg_err), 1);
      check("bad_bpp_busy", int'(bus.busy), 0);
      tick();

      // bpp=3: 8 groups per word, 2 words.
      do_start(3, 0, 2);
      check("A_cfg_err_clr", int'(bus.cfg_err), 0);
      check("A_busy", int'(bus.busy), 1);
      px(1, 0, 0); px(1, 0, 0); px(1, 1, 0); px(1, 0, 0);
      check("A_run_img", int'(bus.img_addr), 4);
      repeat (4) px(1, 0, 0);
      bus.pix_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("A_stall_embed", int'(bus.embed_en), 0);
         tick();
      end
      $display("stall: img_addr=%0d enc_addr=%0d bit_ptr=%0d", bus.img_addr, bus.enc_addr, bus.bit_ptr);
      check("A_stall_img", int'(bus.img_addr), 8);
      check("A_stall_enc", int'(bus.enc_addr), 4);
      check("A_stall_bit", int'(bus.bit_ptr), 12);
      repeat (4) px(1, 0, 0);
      check("A_word1_addr", int'(bus.data_addr), 1);
      check("A_word1_bit", int'(bus.bit_ptr), 0);
      repeat (8) px(1, 0, 0);
      check("A_msg_done", int'(bus.msg_done), 1);
      check("A_final_addr", int'(bus.data_addr), 2);
      bus.pix_valid = 1'b1;
      #1;
      check("A_no_embed_after_done", int'(bus.embed_en), 0);
      run_to_done(60, dones);
      check("A_done_once", dones, 1);
      check("A_busy_fall", int'(bus.busy), 0);
      check("A_img_last", int'(bus.img_addr), IMG_PIXELS - 1);
      check("A_enc_last", int'(bus.enc_addr), 36);

      // bpp=5: cursor 0,5,10,15 then next word; then abort by reset.
      do_start(5, 0, 3);
      px(1, 1, 0); px(1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check("B_bit_ptr", int'(bus.bit_ptr), bseq[i]);
         check("B_data_addr", int'(bus.data_addr), dseq[i]);
         px(1, 0, 0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      $display("mid-pass reset: busy=%0d img_addr=%0d done=%0d", bus.busy, bus.img_addr, bus.done);
      check("B_rst_busy", int'(bus.busy), 0);
      check("B_rst_img", int'(bus.img_addr), 0);
      check("B_rst_enc", int'(bus.enc_addr), 0);
      check("B_rst_bit", int'(bus.bit_ptr), 0);
      check("B_rst_data", int'(bus.data_addr), 0);
      for (int i = 0; i < 3; i++) begin
         px(1, 0, 0);
         check("B_rst_no_done", int'(bus.done), 0);
      end

      // Edge-only embedding with alternating edge flags.
      do_start(2, 1, 5);
      px(1, 1, 0); px(1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         bus.pix_valid = 1'b1; bus.flag_img_start = 1'b0; bus.flag_edge = (i % 2 == 0);
         #1;
         check("C_embed_edge", int'(bus.embed_en), (i % 2 == 0) ? 1 : 0);
         tick();
      end
      check("C_bit_ptr", int'(bus.bit_ptr), 10);
      check("C_data_addr", int'(bus.data_addr), 0);
      check("C_enc_addr", int'(bus.enc_addr), 10);
      run_to_done(60, dones);
      check("C_done_once", dones, 1);

      // Empty message, then a restart from zero.
      do_start(6, 0, 0);
      check("D_msg_done_empty", int'(bus.msg_done), 1);
      px(1, 1, 0); px(1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         bus.pix_valid = 1'b1; bus.flag_edge = 1'b1;
         #1;
         check("D_no_embed", int'(bus.embed_en), 0);
         tick();
      end
      run_to_done(60, dones);
      check("D_done_once", dones, 1);
      do_start(1, 0, 1);
      check("D_restart_img", int'(bus.img_addr), 0);
      check("D_restart_enc", int'(bus.enc_addr), 0);
      check("D_restart_msg_done", int'(bus.msg_done), 0);
      check("D_restart_busy", int'(bus.busy), 1);
      repeat (3) px(1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
